// File: rtl/sb_i2c_cfg_master.sv
// Sequencer that turns one-shot {dev, reg, data} write commands into register
// accesses on the iCE40UP hard I2C system bus: init, START/WR/STOP, status polling.
module sb_i2c_cfg_master #(
    parameter logic [3:0]  BUS_ADDR74   = 4'b0001,
    parameter logic [9:0]  PRESCALE     = 10'd30,
    parameter logic [15:0] POLL_TIMEOUT = 16'd60000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    // Command handshake: a command transfers on the rising clk_i edge where
    // cmd_valid_i && cmd_ready_o; the source holds cmd_* stable until then.
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_dev_i,
    input  logic [7:0] cmd_reg_i,
    input  logic [7:0] cmd_data_i,
    output logic       done_o,
    output logic       nack_o,
    output logic       timeout_o,
    output logic       init_done_o,
    output logic       sb_stb_o,
    output logic       sb_rw_o,
    output logic [7:0] sb_adr_o,
    output logic [7:0] sb_dat_o,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack_i
);

    localparam logic [3:0] OFS_CR1   = 4'h8;
    localparam logic [3:0] OFS_CMDR  = 4'h9;
    localparam logic [3:0] OFS_BRLSB = 4'hA;
    localparam logic [3:0] OFS_BRMSB = 4'hB;
    localparam logic [3:0] OFS_SR    = 4'hC;
    localparam logic [3:0] OFS_TXDR  = 4'hD;

    localparam logic [7:0] CR1_EN       = 8'h80;
    localparam logic [7:0] CMD_START_WR = 8'h94;
    localparam logic [7:0] CMD_WR       = 8'h14;
    localparam logic [7:0] CMD_STOP     = 8'h44;

    localparam int SR_BUSY  = 6;
    localparam int SR_RARC  = 5;
    localparam int SR_TRRDY = 2;

    typedef enum logic [3:0] {
        ST_INIT_BRL,
        ST_INIT_BRH,
        ST_INIT_CR1,
        ST_IDLE,
        ST_TX,
        ST_CMD,
        ST_POLL,
        ST_STOP,
        ST_POLL_IDLE,
        ST_DONE
    } state_e;

    // Bus access phase: ISSUE raises stb, WAIT holds it until ack, GAP keeps
    // stb low one cycle and lets the main FSM act on the finished access.
    typedef enum logic [1:0] {
        ACC_ISSUE,
        ACC_WAIT,
        ACC_GAP
    } acc_e;

    state_e      state_q;
    acc_e        acc_q;
    logic [1:0]  idx_q;
    logic [15:0] cnt_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  data_q;
    logic [7:0]  sr_q;
    logic        ready_q;
    logic        done_q;
    logic        nack_q;
    logic        timeout_q;
    logic        init_done_q;
    logic        stb_q;
    logic        rw_q;
    logic [7:0]  adr_q;
    logic [7:0]  dat_q;

    logic        acc_wr_d;
    logic [3:0]  acc_ofs_d;
    logic [7:0]  acc_dat_d;
    logic        poll_ok_d;
    logic        timed_out_d;
    logic        unused_sr;

    always_comb begin
        acc_wr_d  = 1'b0;
        acc_ofs_d = OFS_SR;
        acc_dat_d = 8'h00;
        case (state_q)
            ST_INIT_BRL: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_BRLSB;
                acc_dat_d = PRESCALE[7:0];
            end
            ST_INIT_BRH: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_BRMSB;
                acc_dat_d = {6'b000000, PRESCALE[9:8]};
            end
            ST_INIT_CR1: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_CR1;
                acc_dat_d = CR1_EN;
            end
            ST_TX: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_TXDR;
                case (idx_q)
                    2'd0:    acc_dat_d = {dev_q, 1'b0};
                    2'd1:    acc_dat_d = reg_q;
                    default: acc_dat_d = data_q;
                endcase
            end
            ST_CMD: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_CMDR;
                acc_dat_d = (idx_q == 2'd0) ? CMD_START_WR : CMD_WR;
            end
            ST_STOP: begin
                acc_wr_d  = 1'b1;
                acc_ofs_d = OFS_CMDR;
                acc_dat_d = CMD_STOP;
            end
            default: begin
                acc_wr_d  = 1'b0;
                acc_ofs_d = OFS_SR;
                acc_dat_d = 8'h00;
            end
        endcase
    end

    // Address/register bytes wait for TRRDY; the final byte waits for the bus to go idle.
    assign poll_ok_d   = (state_q == ST_POLL && idx_q != 2'd2) ? sr_q[SR_TRRDY] : !sr_q[SR_BUSY];
    assign timed_out_d = (cnt_q >= POLL_TIMEOUT);
    assign unused_sr   = ^{sr_q[7], sr_q[4:3], sr_q[1:0]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_INIT_BRL;
            acc_q       <= ACC_ISSUE;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            dev_q       <= 7'd0;
            reg_q       <= 8'd0;
            data_q      <= 8'd0;
            sr_q        <= 8'd0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
            timeout_q   <= 1'b0;
            init_done_q <= 1'b0;
            stb_q       <= 1'b0;
            rw_q        <= 1'b0;
            adr_q       <= 8'd0;
            dat_q       <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == ST_POLL || state_q == ST_POLL_IDLE) && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        dev_q     <= cmd_dev_i;
                        reg_q     <= cmd_reg_i;
                        data_q    <= cmd_data_i;
                        ready_q   <= 1'b0;
                        nack_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        idx_q     <= 2'd0;
                        acc_q     <= ACC_ISSUE;
                        state_q   <= ST_TX;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    case (acc_q)
                        ACC_ISSUE: begin
                            stb_q <= 1'b1;
                            rw_q  <= acc_wr_d;
                            adr_q <= {BUS_ADDR74, acc_ofs_d};
                            dat_q <= acc_dat_d;
                            acc_q <= ACC_WAIT;
                        end
                        ACC_WAIT: begin
                            if (sb_ack_i) begin
                                stb_q <= 1'b0;
                                if (!rw_q) begin
                                    sr_q <= sb_dat_i;
                                end
                                acc_q <= ACC_GAP;
                            end
                        end
                        default: begin
                            acc_q <= ACC_ISSUE;
                            case (state_q)
                                ST_INIT_BRL: state_q <= ST_INIT_BRH;
                                ST_INIT_BRH: state_q <= ST_INIT_CR1;
                                ST_INIT_CR1: begin
                                    init_done_q <= 1'b1;
                                    ready_q     <= 1'b1;
                                    state_q     <= ST_IDLE;
                                end
                                ST_TX: state_q <= ST_CMD;
                                ST_CMD: begin
                                    cnt_q   <= 16'd0;
                                    state_q <= ST_POLL;
                                end
                                ST_POLL: begin
                                    if (poll_ok_d) begin
                                        if (sr_q[SR_RARC]) begin
                                            nack_q  <= 1'b1;
                                            state_q <= ST_STOP;
                                        end else if (idx_q == 2'd2) begin
                                            state_q <= ST_STOP;
                                        end else begin
                                            idx_q   <= idx_q + 2'd1;
                                            state_q <= ST_TX;
                                        end
                                    end else if (timed_out_d) begin
                                        timeout_q <= 1'b1;
                                        state_q   <= ST_STOP;
                                    end
                                end
                                ST_STOP: begin
                                    cnt_q   <= 16'd0;
                                    state_q <= ST_POLL_IDLE;
                                end
                                ST_POLL_IDLE: begin
                                    if (poll_ok_d) begin
                                        done_q  <= 1'b1;
                                        state_q <= ST_DONE;
                                    end else if (timed_out_d) begin
                                        // Timeout wins so the two status flags stay exclusive.
                                        timeout_q <= 1'b1;
                                        nack_q    <= 1'b0;
                                        done_q    <= 1'b1;
                                        state_q   <= ST_DONE;
                                    end
                                end
                                default: state_q <= ST_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign nack_o      = nack_q;
    assign timeout_o   = timeout_q;
    assign init_done_o = init_done_q;
    assign sb_stb_o    = stb_q;
    assign sb_rw_o     = rw_q;
    assign sb_adr_o    = adr_q;
    assign sb_dat_o    = dat_q;

endmodule
